data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory slave on the far end of the CPU MEM-stage interface.
- Accepts one read or write request at a time, driven by the MemEnab/MemWrite control bits, address and store data.
- Inserts a programmable number of wait states, then returns Ready, read data and an error flag.
- Drives Stall back to the pipeline so the MEM stage and all earlier stages hold while an access is outstanding.

Parameters:
- ADDR_W, 8: implemented word-address bits; array depth is 2^ADDR_W 16-bit words.
- WAIT_CYCLES, 2: wait states between request acceptance and the memory access; legal range 0..15.

Ports:
- Clk  in  1  clock; rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- MemEnab  in  1  request valid.
- MemWrite  in  1  1 = write, 0 = read; meaningful only with MemEnab.
- Addr  in  16  word address.
- WData  in  16  store data.
- RData  out  16  load data; valid while Ready=1.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  out-of-range access; valid while Ready=1.
- Stall  out  1  combinational; hold the pipeline.

Behaviour:
- States: IDLE, WAIT, RESP. Internal: latched addr/wdata/write bit, 4-bit wait counter Cnt.
- Reset (Rst=0, immediate):
  - state=IDLE, Ready=0, Err=0, RData=16'h0000, Cnt=0.
  - Latched request cleared; any pending write is discarded.
  - Array contents are not reset.
- IDLE:
  - MemEnab=1 at a rising edge latches Addr, WData and MemWrite.
  - WAIT_CYCLES=0: next state is RESP and the access executes on the same edge.
  - Otherwise: Cnt<=WAIT_CYCLES, next state is WAIT.
- WAIT:
  - Cnt decrements each edge.
  - At the edge where Cnt==1, the access executes and next state is RESP.
- Access (executes on the edge entering RESP):
  - In-range (latched Addr[15:ADDR_W]==0), read: RData<=mem[addr]; Err<=0.
  - In-range, write: mem[addr]<=wdata; RData<=wdata (store echo); Err<=0.
  - Out-of-range: no array write; RData<=16'h0000; Err<=1.
- RESP:
  - Ready=1 for exactly one cycle.
  - Next edge: state=IDLE, Ready<=0, Err<=0. RData holds its value until the next access.
- Latency: request in cycle 0 gives Ready in cycle WAIT_CYCLES+1.
- Stall = (state==IDLE && MemEnab) || state==WAIT.
  - Deasserted in RESP, so the pipeline advances on the edge ending RESP.
- Handshake rules:
  - The requester holds MemEnab, MemWrite, Addr and WData stable until Ready.
  - Input changes during WAIT/RESP are ignored; only the latched copy is used.
  - MemEnab=1 in the cycle after Ready is a new request, so back-to-back accesses cost WAIT_CYCLES+2 cycles each.
  - MemEnab=0 in IDLE: no state change, Stall=0.
- Reset mid-operation (in WAIT or RESP): returns to IDLE with no array update; a subsequent request starts a full wait sequence.
- Read of a never-written in-range word returns X; the bench must initialise locations before reading them.

Test Plan:
1. WAIT_CYCLES=2: write Addr=16'h0010, WData=16'hBEEF in cycle 0 -> Stall=1 in cycles 0-2; Ready=1, Err=0, RData=16'hBEEF in cycle 3 only; Stall=0 in cycle 3.
2. Follow-up read of Addr=16'h0010 -> Ready in cycle 3 of that request, RData=16'hBEEF; an intervening read of 16'h0011 after writing 16'h1234 there returns 16'h1234.
3. WAIT_CYCLES=0: read request in cycle 0 -> Ready=1 in cycle 1; four back-to-back reads complete in cycles 1, 3, 5, 7.
4. ADDR_W=8: write to 16'h0100 with WData=16'hAAAA -> Ready with Err=1, RData=16'h0000; a later read of 16'h0000 returns its prior value, unchanged.
5. Change Addr/WData during WAIT -> access uses the values latched at acceptance.
6. Write to 16'h0020 (prior value 16'h5555) with Rst pulsed low during WAIT -> Ready never asserts, outputs go to reset values immediately; a later read of 16'h0020 returns 16'h5555.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory slave for the MEM stage: accepts one request at a time, waits
// WAIT_CYCLES edges, performs the access and returns a one-cycle Ready pulse.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemEnab,
  input  logic        MemWrite,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  output logic [15:0] RData,
  output logic        Ready,
  output logic        Err,
  output logic        Stall,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam int         DEPTH     = 1 << ADDR_W;

  // Handshake: a request is MemEnab=1 while IDLE; the requester holds
  // MemEnab/MemWrite/Addr/WData until Ready, and the block works only from
  // the copy latched at acceptance. Stall holds the pipeline until RESP.

  logic [15:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;

  logic              accept;
  logic              do_access;
  logic              in_range;
  logic              mem_we;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_idx;

  // With no wait states the access happens on the accepting edge, so the
  // live inputs are used there; otherwise the latched copy is used.
  always_comb begin
    accept    = (state_q == IDLE) && MemEnab;
    do_access = (accept && NO_WAIT) || ((state_q == WAIT) && (cnt_q <= 4'd1));
    acc_addr  = (state_q == IDLE) ? Addr     : addr_q;
    acc_wdata = (state_q == IDLE) ? WData    : wdata_q;
    acc_write = (state_q == IDLE) ? MemWrite : write_q;
    acc_idx   = acc_addr[ADDR_W-1:0];
    in_range  = ((acc_addr >> ADDR_W) == 16'h0000);
    mem_we    = do_access && acc_write && in_range;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = Addr;
          wdata_d = WData;
          write_d = MemWrite;
          if (NO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_access) begin
      ready_d = 1'b1;
      err_d   = !in_range;
      if (!in_range) begin
        rdata_d = 16'h0000;
      end else if (acc_write) begin
        rdata_d = acc_wdata;
      end else begin
        rdata_d = mem[acc_idx];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; a write is suppressed while reset is held.
  always_ff @(posedge Clk) begin
    if (mem_we && Rst) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign RData     = rdata_q;
  assign Ready     = ready_q;
  assign Err       = err_q;
  assign Stall     = accept || (state_q == WAIT);
  assign state_dbg = state_q;

endmodule
